// File: rtl/decode_pipe.sv
// RV32I decode stage feeding a BUF_DEPTH-entry bundle FIFO; DECODE_ILLEGAL_EN enables illegal-op flagging and stall.
// Latency: an accepted instruction reaches o_valid one cycle later at the earliest (no bypass).
// Backpressure: o_ready drops when full, on a load-use hazard, during flush, or while an illegal entry is queued.
module decode_pipe #(
  parameter int XLEN             = 32,
  parameter int BUF_DEPTH        = 2,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [5:0]      o_format,
  output logic [2:0]      o_opsel,
  output logic            o_sub,
  output logic            o_arith,
  output logic            o_unsigned,
  output logic            o_alu_src1,
  output logic            o_alu_src2,
  output logic            o_u_zero,
  output logic            o_rd_wen,
  output logic            o_mem_wen,
  output logic            o_mem_to_reg,
  output logic            o_illegal
);

  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int LCW = (LOAD_USE_BUBBLES > 1) ? $clog2(LOAD_USE_BUBBLES + 1) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [5:0]      format;
    logic [2:0]      opsel;
    logic            sub;
    logic            arith;
    logic            unsgn;
    logic            alu_src1;
    logic            alu_src2;
    logic            u_zero;
    logic            rd_wen;
    logic            mem_wen;
    logic            mem_to_reg;
    logic            illegal;
  } bundle_t;

  bundle_t           mem [BUF_DEPTH];
  bundle_t           dec;
  bundle_t           head;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [LCW-1:0]    ld_cnt;
  logic [4:0]        ld_rd;
  logic [BUF_DEPTH-1:0] slot_vld;
  logic              full;
  logic              enq;
  logic              deq;
  logic              hazard;
  logic              ill_queued;
  logic              q_hit1;
  logic              q_hit2;
  logic              use_rs1;
  logic              use_rs2;
  logic              hit1;
  logic              hit2;
  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic              unused_bits;

  assign opcode      = i_inst[6:0];
  assign f3          = i_inst[14:12];
  assign unused_bits = ^{i_inst[31], i_inst[29:25]};

  always_comb begin
    dec     = '0;
    dec.pc  = i_pc;
    dec.rs1 = i_inst[19:15];
    dec.rs2 = i_inst[24:20];
    dec.rd  = i_inst[11:7];
    case (opcode)
      OP_R: begin
        dec.format = FMT_R;
        dec.opsel  = f3;
        dec.sub    = i_inst[30];
        dec.arith  = i_inst[30];
        dec.unsgn  = (f3 == 3'b011);
        dec.rd_wen = 1'b1;
      end
      OP_IMM: begin
        dec.format   = FMT_I;
        dec.opsel    = f3;
        dec.arith    = (f3 == 3'b101) & i_inst[30];
        dec.unsgn    = (f3 == 3'b011);
        dec.alu_src2 = 1'b1;
        dec.rd_wen   = 1'b1;
      end
      OP_LOAD: begin
        dec.format     = FMT_I;
        dec.alu_src2   = 1'b1;
        dec.rd_wen     = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_JALR: begin
        dec.format   = FMT_I;
        dec.alu_src1 = 1'b1;
        dec.alu_src2 = 1'b1;
        dec.rd_wen   = 1'b1;
`ifdef DECODE_ILLEGAL_EN
        dec.illegal  = (f3 != 3'b000);
`endif
      end
      OP_STORE: begin
        dec.format   = FMT_S;
        dec.alu_src2 = 1'b1;
        dec.mem_wen  = 1'b1;
      end
      OP_BRANCH: begin
        dec.format = FMT_B;
        dec.sub    = 1'b1;
        dec.unsgn  = (f3[2:1] == 2'b11);
      end
      OP_LUI: begin
        dec.format   = FMT_U;
        dec.alu_src2 = 1'b1;
        dec.u_zero   = 1'b1;
        dec.rd_wen   = 1'b1;
      end
      OP_AUIPC: begin
        dec.format   = FMT_U;
        dec.alu_src1 = 1'b1;
        dec.alu_src2 = 1'b1;
        dec.rd_wen   = 1'b1;
      end
      OP_JAL: begin
        dec.format   = FMT_J;
        dec.alu_src1 = 1'b1;
        dec.alu_src2 = 1'b1;
        dec.rd_wen   = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
`ifdef DECODE_ILLEGAL_EN
    if (dec.illegal) begin
      dec.rd_wen     = 1'b0;
      dec.mem_wen    = 1'b0;
      dec.mem_to_reg = 1'b0;
    end
`endif
  end

  // Slot i holds live data when its distance from the read pointer is below count.
  always_comb begin
    slot_vld   = '0;
    q_hit1     = 1'b0;
    q_hit2     = 1'b0;
    ill_queued = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      slot_vld[i] = (int'(PW'(i) - rd_ptr) < int'(count));
      if (slot_vld[i]) begin
        if (mem[i].mem_to_reg && (mem[i].rd != 5'd0)) begin
          if (mem[i].rd == dec.rs1) q_hit1 = 1'b1;
          if (mem[i].rd == dec.rs2) q_hit2 = 1'b1;
        end
        if (mem[i].illegal) ill_queued = 1'b1;
      end
    end
  end

  assign use_rs1 = |(dec.format & (FMT_R | FMT_I | FMT_S | FMT_B));
  assign use_rs2 = |(dec.format & (FMT_R | FMT_S | FMT_B));
  assign hit1    = (dec.rs1 != 5'd0) & (q_hit1 | ((ld_cnt != '0) & (dec.rs1 == ld_rd)));
  assign hit2    = (dec.rs2 != 5'd0) & (q_hit2 | ((ld_cnt != '0) & (dec.rs2 == ld_rd)));
  assign hazard  = i_valid & ((use_rs1 & hit1) | (use_rs2 & hit2));

  assign full    = (count == CW'(BUF_DEPTH));
  assign o_valid = (count != '0);
`ifdef DECODE_ILLEGAL_EN
  assign o_ready = !full & !hazard & !i_flush & !ill_queued;
`else
  assign o_ready = !full & !hazard & !i_flush;
`endif
  assign enq = i_valid & o_ready;
  assign deq = o_valid & i_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (BUF_DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ld_cnt <= '0;
      ld_rd  <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ld_cnt <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (deq && head.mem_to_reg && (head.rd != 5'd0)) begin
        ld_rd  <= head.rd;
        ld_cnt <= LCW'(LOAD_USE_BUBBLES);
      end else if (ld_cnt != '0) begin
        ld_cnt <= ld_cnt - 1'b1;
      end
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge i_clk) begin
    if (enq) mem[wr_ptr] <= dec;
  end

  assign head         = o_valid ? mem[rd_ptr] : '0;
  assign o_pc         = head.pc;
  assign o_rs1        = head.rs1;
  assign o_rs2        = head.rs2;
  assign o_rd         = head.rd;
  assign o_format     = head.format;
  assign o_opsel      = head.opsel;
  assign o_sub        = head.sub;
  assign o_arith      = head.arith;
  assign o_unsigned   = head.unsgn;
  assign o_alu_src1   = head.alu_src1;
  assign o_alu_src2   = head.alu_src2;
  assign o_u_zero     = head.u_zero;
  assign o_rd_wen     = head.rd_wen;
  assign o_mem_wen    = head.mem_wen;
  assign o_mem_to_reg = head.mem_to_reg;
  assign o_illegal    = head.illegal;

endmodule
